cache_fill_fsm: RTL
===================

// Module: cache_fill_fsm
// PURPOSE
//   Miss handler for the I-cache and D-cache. On a miss it fetches the whole 16-byte block
//   from multi-cycle main memory: one word request per cycle, then returned words are
//   written into the cache data array in order. The tag is written on the last word.
//   Sits between the cache access logic (which raises miss_detected and stalls the pipeline
//   while fsm_busy=1) and main memory. One instance per cache.
// PARAMETERS
//   WORDS      8   16-bit words per block (block = 16 bytes; offset bits [3:1])
//   ADDR_W     16  byte address width
// PORTS
//   clk                input   1       clock, all state updates on rising edge
//   rst                input   1       asynchronous active-high reset
//   miss_detected      input   1       cache miss this cycle; sampled only in IDLE
//   miss_address       input   ADDR_W  byte address of the missing access
//   memory_data        input   16      word returned by main memory
//   memory_data_valid  input   1       memory_data valid this cycle
//   fsm_busy           output  1       fill in progress; cache must stall requester
//   mem_read           output  1       issue read of memory_address this cycle
//   memory_address     output  ADDR_W  word address sent to main memory
//   write_data_array   output  1       write fill_data to data array at fill_address
//   fill_address       output  ADDR_W  data-array word address for this write
//   fill_data          output  16      equals memory_data (pass-through)
//   write_tag_array    output  1       write tag/valid for block at fill_address
// BEHAVIOUR
//   Reset: state=IDLE, base/issue_cnt/recv_cnt cleared. All outputs 0 while rst=1 and in IDLE.
//   State register (IDLE, FILL). issue_cnt and recv_cnt are clog2(WORDS)+1 bits wide.
//   IDLE:
//     - fsm_busy=0, mem_read=0.
//     - miss_detected=1: latch base={miss_address[15:4],4'b0}, clear counters, go to FILL.
//     - memory_data_valid ignored in IDLE (no write).
//   FILL:
//     - fsm_busy=1 (registered; high from the cycle after the miss).
//     - mem_read=1 while issue_cnt<WORDS.
//     - memory_address=base+{issue_cnt[2:0],1'b0}; issue_cnt++ per cycle while mem_read=1.
//     - memory_data_valid=1 (combinational, same cycle):
//         write_data_array=1, fill_address=base+{recv_cnt[2:0],1'b0}; recv_cnt++.
//     - The valid with recv_cnt==WORDS-1 also asserts write_tag_array=1; next state IDLE.
//   Offset arithmetic stays inside the block: only bits [3:1] vary, bits [15:4]=base, no carry.
//   Memory returns words in request order; the FSM counts valids and does not track latency.
//   Latency (4-cycle memory): miss at cycle 0 gives
//     - requests in cycles 1-8, valids in cycles 5-12;
//     - tag write in cycle 12; fsm_busy=0 from cycle 13.
//   Boundaries:
//     - miss_detected during FILL ignored; base unchanged.
//     - New miss accepted in the first IDLE cycle after completion.
//     - Valid in a cycle with mem_read=1: issue and receive both advance.
//     - Gaps in memory_data_valid stall recv_cnt only.
//     - Extra valids after WORDS received are ignored (state already IDLE).
//     - rst asserted mid-fill: immediate return to IDLE, no tag write; partial block stays tag-invalid.
//   When write_data_array=0, fill_address and fill_data are don't-care.
// TESTING
//   1. miss 0x1236 at cycle 0, memory valid 4 cycles after each request ->
//      memory_address 0x1230,0x1232..0x123E in cycles 1-8; 8 data writes to 0x1230..0x123E in
//      cycles 5-12; write_tag_array only in cycle 12; fsm_busy 1 in cycles 1-12.
//   2. miss 0xFFFE -> base 0xFFF0, addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
//   3. second miss 0x4000 asserted in cycle 6 of a fill -> ignored; miss in cycle 13 starts
//      a fill at 0x4000 with mem_read=1 in cycle 14.
//   4. valids with gaps (pattern 1,0,0,1,...) -> writes occur exactly on valid cycles, in
//      order 0x..0 to 0x..E; tag write on the 8th valid.
//   5. rst pulsed in cycle 7 of a fill -> all outputs 0 at once; later valids cause no write;
//      next miss restarts from offset 0.
//   6. memory_data_valid=1 in IDLE with no miss -> write_data_array=0, write_tag_array=0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler that fetches one whole block from main memory.
// On a miss it issues one word read per cycle for every word of the block. It then
// writes the returned words into the data array in request order, and writes the tag
// together with the last word.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   miss_detected       miss this cycle (sampled only while idle)
//   miss_address        byte address of the missing access
//   memory_data/_valid  word returned by main memory and its valid strobe
//   fsm_busy            fill in progress (requester must stall)
//   mem_read            read request for memory_address this cycle
//   memory_address      word address sent to main memory
//   write_data_array    write fill_data at fill_address
//   fill_address        data-array word address of the write
//   fill_data           pass-through of memory_data
//   write_tag_array     write tag/valid for the block at fill_address
module cache_fill_fsm #(
  parameter int unsigned WORDS  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  localparam int unsigned OFF_W     = $clog2(WORDS);
  localparam int unsigned CNT_W     = OFF_W + 1;
  localparam int unsigned BLK_BYTES = WORDS * 2;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(BLK_BYTES - 1));

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Next-state and output decode. base has zero offset bits, so OR-ing in the word
  // offset keeps every address inside the block with no carry into the tag bits.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_address     = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address & BLK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < CNT_W'(WORDS)) begin
          mem_read       = 1'b1;
          memory_address = base_q | ADDR_W'({issue_cnt_q[OFF_W-1:0], 1'b0});
          issue_cnt_d    = issue_cnt_q + CNT_W'(1);
        end
        // Returned words arrive in request order, so counting valids is enough.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_address     = base_q | ADDR_W'({recv_cnt_q[OFF_W-1:0], 1'b0});
          fill_data        = memory_data;
          recv_cnt_d       = recv_cnt_q + CNT_W'(1);
          if (recv_cnt_q == CNT_W'(WORDS - 1)) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
